adder_op_sequencer: RTL and testbench
=====================================

Name: adder_op_sequencer

Overview:
Command sequencer for the shared WIDTH-bit operand adder on the board (switch operands, key-push commands, LED/7-segment result display). It accepts single-cycle command pulses from the push-key synchronisers, latches two operands and time-multiplexes one WIDTH-bit adder. Supported operations: CLEAR, ADD (single pass) and MUL (WIDTH-step shift-and-add). It drives a 2*WIDTH-bit result register plus overflow, busy and done flags to the display logic.

Parameters:
WIDTH, 8, operand width in bits; result is 2*WIDTH bits; iteration counter is clog2(WIDTH) bits wide.

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
cmd_clr  input  1  one-cycle pulse: clear result/overflow, abort any operation
cmd_add  input  1  one-cycle pulse: start ADD
cmd_mul  input  1  one-cycle pulse: start MUL
op_a  input  WIDTH  operand A, sampled only on command accept
op_b  input  WIDTH  operand B, sampled only on command accept
result  output  2*WIDTH  last completed result
overflow  output  1  carry out of ADD; 0 after MUL/CLEAR
busy  output  1  high while state is not IDLE
done  output  1  one-cycle pulse when result/overflow are updated by ADD or MUL

Behaviour:
- Reset (RST high at edge): state=IDLE, result=0, overflow=0, busy=0, done=0, counter=0, internal accumulator=0. RST overrides all commands and aborts any operation in progress.
- States: IDLE, ADD, MUL. busy = (state != IDLE), registered with the state.
- Command priority, sampled every edge: cmd_clr > cmd_add > cmd_mul.
- cmd_clr in any state: result=0, overflow=0, state=IDLE, done=0. An aborted operation produces no done pulse.
- cmd_add/cmd_mul are accepted only in IDLE. In ADD or MUL they are ignored and not queued.
- ADD, accepted at edge N:
  - Edge N: latch op_a/op_b; state goes to ADD.
  - Edge N+1: sum = {1'b0,A}+{1'b0,B} (WIDTH+1 bits); result = zero-extended sum; overflow = sum[WIDTH]; done=1; state goes to IDLE.
  - Latency is 1 cycle.
- MUL, accepted at edge N:
  - Edge N: latch A, B; accumulator=0; counter=0; state goes to MUL.
  - Edges N+1..N+WIDTH: if B[counter], accumulator += A << counter; counter increments. Only the shared WIDTH-bit adder plus carry is used, on the accumulator slice [counter+WIDTH-1:counter].
  - Edge N+WIDTH: result = final product (2*WIDTH bits, can never overflow); overflow=0; done=1; state goes to IDLE.
  - Latency is WIDTH cycles.
- result/overflow hold their previous values for the whole duration of an operation. The accumulator is internal and not visible on result.
- done is high for exactly one cycle, after the completing edge. It is 0 in all other cycles.
- A command pulse in the same cycle that done is high is accepted, because state is already IDLE at that edge.
- Back-to-back: a new command can be accepted at the edge immediately after completion.
- Operand changes after accept have no effect on the operation in progress.
- Counter wraps to 0 on return to IDLE.

Test Plan:
1. Reset: RST=1 for 2 cycles with cmd_add=1 -> result=0x0000, overflow=0, busy=0, done never asserted.
2. ADD carry: op_a=0xFF, op_b=0x01, cmd_add pulse at edge N -> at N+1 result=0x0100, overflow=1, done=1 for one cycle. A second ADD with 0x12+0x34 -> result=0x0046, overflow=0.
3. MUL: op_a=0xFF, op_b=0xFF, cmd_mul pulse -> busy=1 for 8 cycles, result stays at old value until edge N+8, then result=0xFE01, overflow=0, done pulse. Also 0x00*0xAB -> 0x0000 after 8 cycles.
4. Ignore-while-busy and priority: cmd_add pulse at N+3 during MUL 0x03*0x05 -> ignored, result=0x000F at N+8. cmd_add and cmd_mul together in IDLE with 0x10,0x20 -> ADD runs, result=0x0030 after 1 cycle.
5. Abort: cmd_clr at N+4 during MUL 0xFF*0xFF -> result=0, overflow=0, busy=0 next cycle, no done pulse. A subsequent MUL 0x02*0x03 -> 0x0006.
6. RST mid-MUL at N+5 -> all outputs 0. A subsequent ADD 0x01+0x01 -> result=0x0002 after 1 cycle.

Source files
------------

// File: rtl/adder_op_sequencer.sv
// rtl/adder_op_sequencer.sv - command sequencer time-multiplexing one WIDTH-bit adder for CLEAR/ADD/MUL
//
// Accepts single-cycle command pulses, latches two operands and drives the
// display result register. ADD takes one pass through the adder; MUL is a
// WIDTH-step shift-and-add that reuses the same adder on a sliding
// accumulator slice.
//
// Ports:
//   CLK      - system clock, rising edge
//   RST      - synchronous reset, active-high
//   cmd_clr  - pulse: clear result/overflow, abort any operation
//   cmd_add  - pulse: start ADD (accepted in IDLE only)
//   cmd_mul  - pulse: start MUL (accepted in IDLE only)
//   op_a     - operand A, sampled on command accept
//   op_b     - operand B, sampled on command accept
//   result   - last completed result (2*WIDTH bits)
//   overflow - carry out of ADD, 0 after MUL/CLEAR
//   busy     - high while an operation is in progress
//   done     - one-cycle pulse when result/overflow are updated
module adder_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_clr,
  input  logic                 cmd_add,
  input  logic                 cmd_mul,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_MUL
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_d;
  logic                 overflow_d;
  logic                 busy_d;
  logic                 done_d;

  // Shared adder datapath
  logic [AW-1:0]        acc_idx;
  logic [WIDTH-1:0]     add_x;
  logic [WIDTH-1:0]     add_y;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   acc_step;

  assign acc_idx = AW'(cnt_q);

  // In MUL the adder works on acc[cnt+WIDTH-1:cnt]; the carry lands in
  // bit cnt+WIDTH, which is always still zero at that step because the
  // partial product so far is below 2^(WIDTH+cnt).
  always_comb begin
    add_x = a_q;
    add_y = b_q;
    if (state_q == S_MUL) begin
      add_x = acc_q[acc_idx +: WIDTH];
      add_y = b_q[cnt_q] ? a_q : '0;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y};
  end

  always_comb begin
    acc_step = acc_q;
    acc_step[acc_idx +: (WIDTH + 1)] = add_sum;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result;
    overflow_d = overflow;
    done_d     = 1'b0;

    if (cmd_clr) begin
      // Abort wins over everything and never raises done
      state_d    = S_IDLE;
      cnt_d      = '0;
      result_d   = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_add) begin
            a_d     = op_a;
            b_d     = op_b;
            state_d = S_ADD;
          end else if (cmd_mul) begin
            a_d     = op_a;
            b_d     = op_b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end
        end
        S_ADD: begin
          result_d   = (2 * WIDTH)'(add_sum);
          overflow_d = add_sum[WIDTH];
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
        S_MUL: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d   = acc_step;
            overflow_d = 1'b0;
            done_d     = 1'b1;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result   <= result_d;
      overflow <= overflow_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// tb/tb_adder_op_sequencer.sv - self-checking bench for adder_op_sequencer
module tb_adder_op_sequencer;

  localparam int W = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cmd_clr;
  logic          cmd_add;
  logic          cmd_mul;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [2*W-1:0] result;
  logic          overflow;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Reference state: what the display should show right now
  logic [2*W-1:0] exp_res;
  logic           exp_ovf;

  adder_op_sequencer #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .cmd_clr  (cmd_clr),
    .cmd_add  (cmd_add),
    .cmd_mul  (cmd_mul),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (result),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold_chk(input string tag);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res"},  result, exp_res);
    chk({tag, "_ovf"},  overflow, exp_ovf);
  endtask

  task automatic idle_chk(input string tag);
    step();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res"},  result, exp_res);
    chk({tag, "_ovf"},  overflow, exp_ovf);
  endtask

  task automatic final_chk(input string tag);
    chk({tag, "_res"},  result, exp_res);
    chk({tag, "_ovf"},  overflow, exp_ovf);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // ADD; with both=1 cmd_mul is raised too and must lose to cmd_add
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input bit both);
    int unsigned s;
    op_a = a; op_b = b; cmd_add = 1'b1; cmd_mul = both;
    step();
    cmd_add = 1'b0; cmd_mul = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    hold_chk("add_wait");
    step();
    s = int'(a) + int'(b);
    exp_res = (2*W)'(s);
    exp_ovf = (s > 255);
    final_chk("add_end");
  endtask

  // MUL; inj>0 raises cmd_add just before edge N+inj (must be ignored)
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    op_a = a; op_b = b; cmd_mul = 1'b1;
    step();
    cmd_mul = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    hold_chk("mul_wait");
    for (int i = 1; i <= W; i++) begin
      cmd_add = (i == inj);
      step();
      cmd_add = 1'b0;
      if (i < W) hold_chk("mul_wait");
    end
    exp_res = (2*W)'(int'(a) * int'(b));
    exp_ovf = 1'b0;
    final_chk("mul_end");
  endtask

  // MUL aborted before edge N+k by cmd_clr or RST
  task automatic run_abort(input logic [W-1:0] a, input logic [W-1:0] b, input int k, input bit use_rst);
    op_a = a; op_b = b; cmd_mul = 1'b1;
    step();
    cmd_mul = 1'b0;
    hold_chk("abort_wait");
    for (int i = 1; i < k; i++) begin
      step();
      hold_chk("abort_wait");
    end
    if (use_rst) RST = 1'b1; else cmd_clr = 1'b1;
    step();
    RST = 1'b0; cmd_clr = 1'b0;
    exp_res = '0;
    exp_ovf = 1'b0;
    chk("abort_res",  result, 0);
    chk("abort_ovf",  overflow, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < W; i++) idle_chk("abort_nodone");
  endtask

  initial begin
    RST = 1'b1; cmd_clr = 1'b0; cmd_add = 1'b1; cmd_mul = 1'b0;
    op_a = 8'h5A; op_b = 8'hA5;
    exp_res = '0; exp_ovf = 1'b0;

    // Reset held with cmd_add asserted
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_res",  result, 0);
      chk("rst_ovf",  overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    cmd_add = 1'b0;
    RST = 1'b0;
    idle_chk("post_rst");

    // ADD with carry, then back-to-back ADD issued during the done cycle
    run_add(8'hFF, 8'h01, 1'b0);
    chk("add_carry_val", result, 16'h0100);
    run_add(8'h12, 8'h34, 1'b0);
    chk("add_plain_val", result, 16'h0046);
    idle_chk("done_single");

    // MUL corner values
    run_mul(8'hFF, 8'hFF, 0);
    chk("mul_ff_val", result, 16'hFE01);
    idle_chk("mul_idle");
    run_mul(8'h00, 8'hAB, 0);
    chk("mul_zero_val", result, 16'h0000);

    // cmd_add during MUL ignored
    run_mul(8'h03, 8'h05, 3);
    chk("mul_ign_val", result, 16'h000F);
    idle_chk("ign_not_queued");

    // cmd_add beats cmd_mul
    run_add(8'h10, 8'h20, 1'b1);
    chk("prio_val", result, 16'h0030);
    idle_chk("prio_idle");

    // Set overflow, then abort a MUL with cmd_clr
    run_add(8'hFF, 8'hFF, 1'b0);
    run_abort(8'hFF, 8'hFF, 4, 1'b0);
    run_mul(8'h02, 8'h03, 0);
    chk("after_clr_val", result, 16'h0006);

    // RST mid-MUL
    run_abort(8'hFF, 8'hFF, 5, 1'b1);
    run_add(8'h01, 8'h01, 1'b0);
    chk("after_rst_val", result, 16'h0002);

    // Random mix of operations, gaps and clears
    for (int n = 0; n < 40; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 4);
      if (kind <= 1) begin
        run_add(W'($urandom), W'($urandom), 1'(kind));
      end else if (kind == 2 || kind == 3) begin
        run_mul(W'($urandom), W'($urandom), int'($urandom_range(0, W - 1)));
      end else begin
        cmd_clr = 1'b1; cmd_add = 1'b1;
        step();
        cmd_clr = 1'b0; cmd_add = 1'b0;
        exp_res = '0; exp_ovf = 1'b0;
        chk("rnd_clr_busy", busy, 0);
        chk("rnd_clr_res",  result, 0);
        chk("rnd_clr_done", done, 0);
      end
      if ($urandom_range(0, 1) == 1) idle_chk("rnd_gap");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
